// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  typedef enum logic [1:0] {PER_1, PER_1_5, PER_2} per_sel_t;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  // Frame-shaping fields held for the character in flight.
  typedef struct packed {
    logic [1:0] wls;
    logic       stb;
    logic       pen;
  } lcr_t;

  // Only bits 0..wls+4 take part in parity.
  function automatic logic tx_parity(input logic [7:0] data, input logic [1:0] wls,
                                     input logic eps, input logic sp);
    logic [7:0] mask;
    logic       x;
    case (wls)
      WLS_5:   mask = 8'h1F;
      WLS_6:   mask = 8'h3F;
      WLS_7:   mask = 8'h7F;
      default: mask = 8'hFF;
    endcase
    x = ^(data & mask);
    if (sp) return ~eps;
    return eps ? x : ~x;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Counts oversample ticks and flags the cycle in which the current bit period ends.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic     CLK,
  input  logic     RST,
  input  logic     BAUDCE,
  input  logic     clear_i,
  input  per_sel_t per_i,
  output logic     bit_end_o
);

  localparam int CW = $clog2(2 * OVERSAMPLE);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] last;

  always_comb begin
    case (per_i)
      PER_1_5: last = CW'(3 * OVERSAMPLE / 2 - 1);
      PER_2:   last = CW'(2 * OVERSAMPLE - 1);
      default: last = CW'(OVERSAMPLE - 1);
    endcase
  end

  assign bit_end_o = BAUDCE && !clear_i && (cnt_q == last);

  // Returning to zero at the period end means each new bit starts from a fresh count.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                       cnt_q <= '0;
    else if (clear_i || bit_end_o)  cnt_q <= '0;
    else if (BAUDCE)                cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: accepts one character by valid/ready and serialises it on TXD.
module uart_tx_sequencer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BAUDCE,
  input  logic [1:0] LCR_WLS,
  input  logic       LCR_STB,
  input  logic       LCR_PEN,
  input  logic       LCR_EPS,
  input  logic       LCR_SP,
  input  logic       LCR_BC,
  input  logic       TX_VALID,
  input  logic [7:0] TX_DATA,
  output logic       TX_READY,
  output logic       TXD,
  output logic       TX_BUSY,
  output logic       TX_DONE
);

  tx_state_t  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  lcr_t       lcr_q;
  logic       par_q;
  logic       ready_q, txd_q, busy_q, done_q;
  logic       done_d, txd_d;
  logic       transfer, bit_end;
  per_sel_t   per_sel;

  assign transfer = TX_VALID && ready_q;

  always_comb begin
    per_sel = PER_1;
    if (state_q == STOP && lcr_q.stb)
      per_sel = (lcr_q.wls == WLS_5) ? PER_1_5 : PER_2;
  end

  uart_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_timer (
    .CLK       (CLK),
    .RST       (RST),
    .BAUDCE    (BAUDCE),
    .clear_i   (state_q == IDLE),
    .per_i     (per_sel),
    .bit_end_o (bit_end)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (transfer) begin
        state_d  = START;
        shift_d  = TX_DATA;
        bitcnt_d = '0;
      end
      START: if (bit_end) state_d = DATA;
      DATA: if (bit_end) begin
        shift_d = shift_q >> 1;
        if (bitcnt_q == {1'b0, lcr_q.wls} + 3'd4) begin
          state_d  = lcr_q.pen ? PARITY : STOP;
          bitcnt_d = '0;
        end else begin
          bitcnt_d = bitcnt_q + 3'd1;
        end
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP: if (bit_end) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // TXD follows the next state so the line and the FSM change on the same edge.
  always_comb begin
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      PARITY:  txd_d = par_q;
      default: txd_d = 1'b1;
    endcase
    if (LCR_BC) txd_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bitcnt_q <= '0;
      lcr_q    <= '0;
      par_q    <= 1'b0;
      ready_q  <= 1'b1;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      ready_q  <= (state_q == IDLE) && !transfer;
      txd_q    <= txd_d;
      busy_q   <= (state_d != IDLE);
      done_q   <= done_d;
      if (transfer) begin
        lcr_q <= '{wls: LCR_WLS, stb: LCR_STB, pen: LCR_PEN};
        par_q <= tx_parity(TX_DATA, LCR_WLS, LCR_EPS, LCR_SP);
      end
    end
  end

  assign TX_READY = ready_q;
  assign TXD      = txd_q;
  assign TX_BUSY  = busy_q;
  assign TX_DONE  = done_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Scoreboard bench: stimulus queues hand-written frame images, a monitor captures TXD per frame.
module tb_uart_tx_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       BAUDCE = 1'b1;
  logic [1:0] LCR_WLS = 2'b11;
  logic       LCR_STB = 1'b0, LCR_PEN = 1'b0, LCR_EPS = 1'b0, LCR_SP = 1'b0, LCR_BC = 1'b0;
  logic       TX_VALID = 1'b0;
  logic [7:0] TX_DATA = 8'h00;
  logic       TX_READY, TXD, TX_BUSY, TX_DONE;

  uart_tx_sequencer #(.OVERSAMPLE(16)) dut (
    .CLK(CLK), .RST(RST), .BAUDCE(BAUDCE),
    .LCR_WLS(LCR_WLS), .LCR_STB(LCR_STB), .LCR_PEN(LCR_PEN), .LCR_EPS(LCR_EPS),
    .LCR_SP(LCR_SP), .LCR_BC(LCR_BC),
    .TX_VALID(TX_VALID), .TX_DATA(TX_DATA), .TX_READY(TX_READY),
    .TXD(TXD), .TX_BUSY(TX_BUSY), .TX_DONE(TX_DONE)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  int exp_len_q[$];
  bit exp_bits_q[$];

  // BAUDCE divider; a new sync request puts a pulse in the transfer cycle.
  int baud_div = 1;
  int sync_req = 0;
  int sync_seen = 0;
  int bcnt = 0;
  always begin
    @(posedge CLK);
    #2;
    if (sync_req != sync_seen) begin
      sync_seen = sync_req;
      bcnt = 0;
    end else begin
      bcnt = (bcnt + 1 >= baud_div) ? 0 : bcnt + 1;
    end
    BAUDCE = (bcnt == 0);
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // s = start + data + parity bits in line order; then stop; cycles bf..bt forced low (break).
  task automatic push_frame(input string s, input int bitlen, input int stoplen,
                            input int bf, input int bt);
    bit q[$];
    for (int i = 0; i < s.len(); i++)
      for (int k = 0; k < bitlen; k++) q.push_back(s[i] == 8'h31);
    for (int k = 0; k < stoplen; k++) q.push_back(1'b1);
    for (int i = bf; i <= bt; i++) q[i] = 1'b0;
    exp_len_q.push_back(q.size());
    foreach (q[i]) exp_bits_q.push_back(q[i]);
  endtask

  // Monitor
  int  cyc = 0;
  bit  in_frame = 0;
  bit  chk_ready = 0;
  int  frame_no = 0;
  int  last_done = 0;
  bit  b2b_mode = 0;
  bit  gap_arm = 0;
  bit  act_q[$];

  always @(negedge CLK) begin
    cyc++;
    if (!RST) begin
      in_frame  = 0;
      chk_ready = 0;
      gap_arm   = 0;
      act_q.delete();
    end else begin
      if (chk_ready) begin
        check("ready_after_done", int'(TX_READY), 1);
        chk_ready = 0;
      end
      if (TX_BUSY && !in_frame) begin
        in_frame = 1;
        act_q.delete();
        if (gap_arm) begin
          check("b2b_gap", cyc - last_done, 2);
          gap_arm = 0;
        end
      end
      if (in_frame && TX_BUSY) act_q.push_back(TXD);
      if (in_frame && !TX_BUSY) begin
        in_frame = 0;
        last_done = cyc;
        frame_no++;
        check("done_pulse", int'(TX_DONE), 1);
        check("ready_low_at_done", int'(TX_READY), 0);
        chk_ready = 1;
        if (b2b_mode) gap_arm = 1;
        total++;
        if (exp_len_q.size() == 0) begin
          bad++;
          $display("FAIL frame%0d: got unexpected frame len=%0d, want none", frame_no, act_q.size());
        end else begin
          int n, first;
          bit e;
          n = exp_len_q.pop_front();
          first = -1;
          for (int i = 0; i < n; i++) begin
            e = exp_bits_q.pop_front();
            if (first < 0 && (i >= act_q.size() || act_q[i] !== e)) first = i;
          end
          if (first < 0 && act_q.size() != n) first = n;
          if (first >= 0) begin
            bad++;
            $display("FAIL frame%0d: got len=%0d first_diff_cycle=%0d, want len=%0d",
                     frame_no, act_q.size(), first, n);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_busy(input logic lvl);
    int n = 0;
    while (TX_BUSY !== lvl && n < 3000) begin tick(); n++; end
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL wait_busy: got timeout, want TX_BUSY=%0d", lvl);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] wls, input logic stb,
                      input logic pen, input logic eps, input logic sp);
    int n = 0;
    while (TX_READY !== 1'b1 && n < 3000) begin tick(); n++; end
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL wait_ready: got timeout, want TX_READY=1");
    end
    TX_DATA = d; LCR_WLS = wls; LCR_STB = stb; LCR_PEN = pen; LCR_EPS = eps; LCR_SP = sp;
    TX_VALID = 1'b1;
    sync_req++;
    tick();
    TX_VALID = 1'b0;
  endtask

  task automatic finish_frame();
    wait_busy(1'b0);
    repeat (3) tick();
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_txd",   int'(TXD), 1);
    check("rst_ready", int'(TX_READY), 1);
    check("rst_busy",  int'(TX_BUSY), 0);
    check("rst_done",  int'(TX_DONE), 0);
    tick(); tick();
    RST = 1'b1;
    repeat (2) tick();

    // Reset in the middle of DATA aborts the frame immediately
    send(8'h00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (30) tick();
    check("pre_rst_txd", int'(TXD), 0);
    #2 RST = 1'b0;
    #1;
    check("midrst_txd",   int'(TXD), 1);
    check("midrst_busy",  int'(TX_BUSY), 0);
    check("midrst_ready", int'(TX_READY), 1);
    tick();
    RST = 1'b1;
    repeat (2) tick();

    // 8N1 0x55
    push_frame("010101010", 16, 16, 0, -1);
    send(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    finish_frame();

    // 7E1 / 7O1 0xA5
    push_frame("010100101", 16, 16, 0, -1);
    send(8'hA5, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
    finish_frame();
    push_frame("010100100", 16, 16, 0, -1);
    send(8'hA5, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
    finish_frame();

    // Stop lengths and stick parity
    push_frame("011001", 16, 24, 0, -1);
    send(8'h13, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    finish_frame();
    push_frame("0001101", 16, 32, 0, -1);
    send(8'h2C, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    finish_frame();
    push_frame("0000000001", 16, 16, 0, -1);
    send(8'h00, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
    finish_frame();

    // BAUDCE every 4 CLK, WLS changed mid-frame
    baud_div = 4;
    push_frame("000001111", 64, 64, 0, -1);
    send(8'hF0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (100) tick();
    LCR_WLS = 2'b00;
    finish_frame();
    baud_div = 1;
    LCR_WLS = 2'b11;

    // Break during DATA: line low for cycles 41..70, timing unchanged
    push_frame("010101010", 16, 16, 41, 70);
    send(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (40) tick();
    LCR_BC = 1'b1;
    repeat (30) tick();
    LCR_BC = 1'b0;
    finish_frame();

    // Back-to-back with TX_VALID held high
    push_frame("000111100", 16, 16, 0, -1);
    push_frame("000111100", 16, 16, 0, -1);
    b2b_mode = 1;
    TX_DATA = 8'h3C; LCR_WLS = 2'b11; LCR_STB = 1'b0; LCR_PEN = 1'b0;
    TX_VALID = 1'b1;
    wait_busy(1'b1);
    wait_busy(1'b0);
    wait_busy(1'b1);
    TX_VALID = 1'b0;
    finish_frame();
    b2b_mode = 0;

    repeat (5) tick();
    check("frames_pending", exp_len_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1);
  end

endmodule
